// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcodes, operation classes, loader error codes.
// Consumed by the control decoder and by the instruction encode loader.
package mips_isa_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [OPC_W-1:0] {
    OPC_R       = 3'd0,
    OPC_LW      = 3'd1,
    OPC_SW      = 3'd2,
    OPC_BEQ     = 3'd3,
    OPC_BNE     = 3'd4,
    OPC_J       = 3'd5,
    OPC_JAL     = 3'd6,
    OPC_ILLEGAL = 3'd7
  } op_class_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
  localparam logic [1:0] ERR_ADDR_OVF   = 2'd2;

  // Symbolic instruction descriptor as presented on the load stream
  typedef struct packed {
    logic [OPC_W-1:0]    op;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    shamt;
    logic [FUNCT_W-1:0]  funct;
    logic [IMM_W-1:0]    imm;
    logic [TARGET_W-1:0] target;
  } instr_desc_t;

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational packing of a symbolic descriptor into a 32-bit MIPS word.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  instr_desc_t       desc,
  output logic [WORD_W-1:0] word_c,
  output logic              illegal_c
);

  // Select the instruction format from the operation class
  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (op_class_e'(desc.op))
      OPC_R:   word_c = {OP_RTYPE, desc.rs, desc.rt, desc.rd, desc.shamt, desc.funct};
      OPC_LW:  word_c = {OP_LW,  desc.rs, desc.rt, desc.imm};
      OPC_SW:  word_c = {OP_SW,  desc.rs, desc.rt, desc.imm};
      OPC_BEQ: word_c = {OP_BEQ, desc.rs, desc.rt, desc.imm};
      OPC_BNE: word_c = {OP_BNE, desc.rs, desc.rt, desc.imm};
      OPC_J:   word_c = {OP_J,   desc.target};
      OPC_JAL: word_c = {OP_JAL, desc.target};
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes a stream of instruction descriptors and writes them sequentially
// into IMEM from a start address. Optional running XOR checksum of the
// written words is built when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPC_W-1:0]    in_op,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [REG_W-1:0]    in_shamt,
  input  logic [FUNCT_W-1:0]  in_funct,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic [TARGET_W-1:0] in_target,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [WORD_W-1:0]   checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]        state_q, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [CNT_W-1:0]  rem_q, rem_nxt, rem_dec;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [WORD_W-1:0] mem_wdata_nxt;
  logic              err_nxt;
  logic [1:0]        err_code_nxt;
  instr_desc_t       desc;
  logic [WORD_W-1:0] word_c;
  logic              illegal_c;

  assign desc = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                  funct: in_funct, imm: in_imm, target: in_target};

  instr_field_encoder u_enc (
    .desc      (desc),
    .word_c    (word_c),
    .illegal_c (illegal_c)
  );

  assign rem_dec = rem_q - CNT_W'(1);

  // Next-state, counter and registered-output decisions
  always_comb begin
    state_nxt     = state_q;
    addr_nxt      = addr_q;
    rem_nxt       = rem_q;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    err_nxt       = err;
    err_code_nxt  = err_code;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          addr_nxt     = base_addr;
          rem_nxt      = count;
          err_nxt      = 1'b0;
          err_code_nxt = ERR_NONE;
          state_nxt    = (count == '0) ? S_DONE : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        // in_ready is high throughout ACCEPT, so in_valid alone completes the handshake
        if (in_valid) begin
          if (illegal_c) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_ILLEGAL_OP;
            state_nxt    = S_ERR;
          end else begin
            mem_addr_nxt  = addr_q;
            mem_wdata_nxt = word_c;
            state_nxt     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_nxt = addr_q + ADDR_W'(1);
        rem_nxt  = rem_dec;
        if (rem_dec == '0) begin
          state_nxt = S_DONE;
        end else if (addr_q == LAST_ADDR) begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_ADDR_OVF;
          state_nxt    = S_ERR;
        end else begin
          state_nxt = S_ACCEPT;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state_q   <= state_nxt;
      addr_q    <= addr_nxt;
      rem_q     <= rem_nxt;
      in_ready  <= (state_nxt == S_ACCEPT);
      mem_we    <= (state_nxt == S_WRITE);
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= !((state_nxt == S_IDLE) || (state_nxt == S_ERR));
      done      <= (state_nxt == S_DONE);
      err       <= err_nxt;
      err_code  <= err_code_nxt;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic chk_clr;
  logic chk_upd;

  assign chk_clr = start && ((state_q == S_IDLE) || (state_q == S_ERR));
  assign chk_upd = (state_q == S_WRITE);

  // Running XOR of words written in the current job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (chk_clr) begin
      checksum <= '0;
    end else if (chk_upd) begin
      checksum <= checksum ^ mem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
